// File: rtl/icache_pkg.sv
// Shared geometry, address-field helpers and types for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_BYTES = 16;
  localparam int NUM_LINES  = 64;
  localparam int ADDR_BITS  = 18;

  localparam int OB        = $clog2(LINE_BYTES);
  localparam int IB        = $clog2(NUM_LINES);
  localparam int TAG_BITS  = ADDR_BITS - OB - IB;
  localparam int LINE_WORDS = LINE_BYTES / 4;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_FILL = 1'b1
  } state_t;

  typedef logic [IB-1:0]                 index_t;
  typedef logic [TAG_BITS-1:0]           tag_t;
  typedef logic [OB-1:0]                 offset_t;
  typedef logic [LINE_WORDS-1:0][31:0]   line_t;
  typedef logic [LINE_BYTES-1:0][7:0]    line_bytes_t;

  function automatic index_t addr_index(input logic [ADDR_BITS-1:0] a);
    return a[OB+IB-1:OB];
  endfunction

  function automatic tag_t addr_tag(input logic [ADDR_BITS-1:0] a);
    return a[ADDR_BITS-1:OB+IB];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher request/response and memory-arbiter fill signals of the instruction cache.
interface icache_if;
  logic [31:0] addr;
  logic        rn;
  logic [31:0] Inst;
  logic        Read_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        mem_byte_valid;

  modport slave (
    input  addr, rn, mem_byte, mem_byte_valid,
    output Inst, Read_ready, mem_req, mem_addr
  );

  modport master (
    output addr, rn, mem_byte, mem_byte_valid,
    input  Inst, Read_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_store.sv
// Tag, valid and data arrays: combinational read port, synchronous whole-line write port.
module icache_store
  import icache_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  index_t rd_index,
  output logic   rd_valid,
  output tag_t   rd_tag,
  output line_t  rd_line,
  input  logic   we,
  input  index_t wr_index,
  input  tag_t   wr_tag,
  input  line_t  wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  tag_t                 tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; valid_q alone decides whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Blocking direct-mapped instruction cache: single-cycle hits, byte-serial line fill on a miss.
module icache
  import icache_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  icache_if.slave bus
);

  state_t                 state_q, state_d;
  offset_t                count_q, count_next;
  line_bytes_t            buf_q, fill_bytes;
  line_t                  fill_line, st_line;
  logic [ADDR_BITS-1:0]   req_addr_q, mem_addr_q, lk_addr;
  logic [31:0]            inst_q;
  logic                   ready_q, mem_req_q;
  logic                   st_valid, hit;
  tag_t                   st_tag;
  logic                   accept_hit, accept_miss, capture, fill_done;
  logic                   unused_bits;

  assign lk_addr = bus.addr[ADDR_BITS-1:0];

  icache_store u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (addr_index(lk_addr)),
    .rd_valid (st_valid),
    .rd_tag   (st_tag),
    .rd_line  (st_line),
    .we       (fill_done),
    .wr_index (addr_index(req_addr_q)),
    .wr_tag   (addr_tag(req_addr_q)),
    .wr_line  (fill_line)
  );

  assign hit = st_valid && (st_tag == addr_tag(lk_addr));

  // The final byte bypasses the buffer so the line is installed on the same edge it arrives.
  always_comb begin
    fill_bytes                 = buf_q;
    fill_bytes[LINE_BYTES-1]   = bus.mem_byte;
  end
  assign fill_line  = line_t'(fill_bytes);
  assign count_next = count_q + offset_t'(1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ICACHE_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ICACHE_IDLE: if (accept_miss) state_d = ICACHE_FILL;
      ICACHE_FILL: if (fill_done)   state_d = ICACHE_IDLE;
      default:                      state_d = ICACHE_IDLE;
    endcase
  end

  always_comb begin
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    capture     = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        if (rdy && bus.rn) begin
          accept_hit  = hit;
          accept_miss = !hit;
        end
      end
      ICACHE_FILL: begin
        if (rdy && bus.mem_byte_valid) begin
          capture   = 1'b1;
          fill_done = (count_q == offset_t'(LINE_BYTES-1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q     <= '0;
      ready_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      req_addr_q <= '0;
      count_q    <= '0;
      buf_q      <= '0;
    end else begin
      if (accept_hit) begin
        inst_q  <= st_line[lk_addr[OB-1:2]];
        ready_q <= 1'b1;
      end
      if (accept_miss) begin
        ready_q    <= 1'b0;
        req_addr_q <= lk_addr;
        mem_req_q  <= 1'b1;
        mem_addr_q <= {lk_addr[ADDR_BITS-1:OB], {OB{1'b0}}};
        count_q    <= '0;
      end
      if (capture) begin
        buf_q[count_q] <= bus.mem_byte;
        count_q        <= count_next;
        mem_addr_q     <= {req_addr_q[ADDR_BITS-1:OB], count_next};
      end
      if (fill_done) begin
        inst_q    <= fill_line[req_addr_q[OB-1:2]];
        ready_q   <= 1'b1;
        mem_req_q <= 1'b0;
      end
    end
  end

  assign bus.Inst       = inst_q;
  assign bus.Read_ready = ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = {{(32-ADDR_BITS){1'b0}}, mem_addr_q};

  assign unused_bits = ^{bus.addr[31:ADDR_BITS], bus.addr[1:0], req_addr_q[1:0]};

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, multi-cycle corner sequences, random traffic vs. a line-level model.
module tb_icache;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;

  icache_if bus ();

  icache dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:(1<<ADDR_BITS)-1];
  bit          m_valid [NUM_LINES];
  int unsigned m_line  [NUM_LINES];

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned w;
    w = (a & ((1 << ADDR_BITS) - 1)) & ~32'h3;
    return {mem[w+3], mem[w+2], mem[w+1], mem[w]};
  endfunction

  function automatic int unsigned line_key(input logic [31:0] a);
    return (a & ((1 << ADDR_BITS) - 1)) >> OB;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned k;
    k = line_key(a);
    return m_valid[k % NUM_LINES] && (m_line[k % NUM_LINES] == k);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
  endtask

  // Presents n bytes of the line at base, with optional idle gaps and a 3-cycle rdy drop before byte stall_at.
  task automatic serve_fill(input int unsigned base, input int n, input bit gaps, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          check("gap_addr", bus.mem_addr, base + i);
          bus.mem_byte_valid = 1'b0;
          bus.mem_byte       = 8'($urandom);
          @(negedge clk);
        end
      end
      if (i == stall_at) begin
        repeat (3) begin
          check("stall_addr", bus.mem_addr, base + i);
          check("stall_req", bus.mem_req, 1);
          rdy                = 1'b0;
          bus.mem_byte_valid = 1'b1;
          bus.mem_byte       = ~mem[base+i];
          @(negedge clk);
        end
        rdy = 1'b1;
      end
      check("fill_addr", bus.mem_addr, base + i);
      check("fill_req_held", bus.mem_req, 1);
      check("fill_not_ready", bus.Read_ready, 0);
      bus.mem_byte       = mem[base+i];
      bus.mem_byte_valid = 1'b1;
      @(negedge clk);
    end
    bus.mem_byte_valid = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input bit exp_hit, input logic [31:0] exp_inst,
                        input bit gaps, input int stall_at);
    int unsigned base, k;
    base = (a & ((1 << ADDR_BITS) - 1)) & ~(LINE_BYTES - 1);
    bus.addr = a;
    bus.rn   = 1'b1;
    rdy      = 1'b1;
    @(negedge clk);
    bus.rn   = 1'b0;
    bus.addr = $urandom;
    if (exp_hit) begin
      check("hit_ready", bus.Read_ready, 1);
      check("hit_inst", bus.Inst, exp_inst);
      check("hit_no_req", bus.mem_req, 0);
    end else begin
      check("miss_ready_low", bus.Read_ready, 0);
      check("miss_req", bus.mem_req, 1);
      serve_fill(base, LINE_BYTES, gaps, stall_at);
      check("fill_ready", bus.Read_ready, 1);
      check("fill_inst", bus.Inst, exp_inst);
      check("fill_req_low", bus.mem_req, 0);
      k = line_key(a);
      m_valid[k % NUM_LINES] = 1'b1;
      m_line[k % NUM_LINES]  = k;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 2_000_000);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_BITS); i++) mem[i] = 8'($urandom);
    for (int i = 0; i < LINE_BYTES; i++) begin
      mem[32'h100 + i] = 8'(i);
      mem[32'h500 + i] = 8'(8'hA0 + i);
    end
    model_clear();

    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0302_0100};
    vecs[1] = '{32'h0000_0104, 1'b1, 32'h0706_0504};
    vecs[2] = '{32'h0000_0108, 1'b1, 32'h0B0A_0908};
    vecs[3] = '{32'h0000_010C, 1'b1, 32'h0F0E_0D0C};
    vecs[4] = '{32'h0000_0500, 1'b0, 32'hA3A2_A1A0};
    vecs[5] = '{32'h0000_0100, 1'b0, 32'h0302_0100};
    vecs[6] = '{32'h0000_0104, 1'b1, 32'h0706_0504};

    bus.addr = '0;
    bus.rn = 1'b0;
    bus.mem_byte = '0;
    bus.mem_byte_valid = 1'b0;

    // Reset state
    #1;
    check("rst_ready", bus.Read_ready, 0);
    check("rst_inst", bus.Inst, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Cold miss, back-to-back hits, conflict refill, hit again
    for (int i = 0; i < 7; i++) do_req(vecs[i].addr, vecs[i].hit, vecs[i].inst, 1'b0, -1);

    // Stall: rn low for five cycles holds the last result, no fill starts
    repeat (5) begin
      bus.addr = 32'h0000_7000;
      @(negedge clk);
      check("stall_ready", bus.Read_ready, 1);
      check("stall_inst", bus.Inst, 32'h0706_0504);
      check("stall_no_req", bus.mem_req, 0);
    end

    // rdy low in IDLE: a missing request is not accepted
    rdy = 1'b0;
    bus.addr = 32'h0000_7000;
    bus.rn = 1'b1;
    @(negedge clk);
    bus.rn = 1'b0;
    rdy = 1'b1;
    check("rdy_idle_no_req", bus.mem_req, 0);
    check("rdy_idle_ready", bus.Read_ready, 1);

    // rdy gating mid-fill with wrong bytes offered while frozen
    do_req(32'h0000_2004, 1'b0, mem_word(32'h2004), 1'b0, 5);

    // Reset mid-fill: outputs drop asynchronously, line is not installed
    bus.addr = 32'h0000_3008;
    bus.rn = 1'b1;
    @(negedge clk);
    bus.rn = 1'b0;
    serve_fill(32'h3000, 7, 1'b0, -1);
    #2 rst = 1'b0;
    #1;
    check("midrst_req", bus.mem_req, 0);
    check("midrst_ready", bus.Read_ready, 0);
    check("midrst_inst", bus.Inst, 0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    do_req(32'h0000_3008, 1'b0, mem_word(32'h3008), 1'b0, -1);
    do_req(32'h0000_0104, 1'b0, 32'h0706_0504, 1'b0, -1);

    // Random traffic against the line-level model
    for (int r = 0; r < 200; r++) begin
      logic [31:0] a;
      int          stall;
      a = ($urandom << ADDR_BITS) | ($urandom_range(0, 3) << (OB + IB))
        | ($urandom_range(0, 7) << OB) | $urandom_range(0, LINE_BYTES - 1);
      stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LINE_BYTES - 1)) : -1;
      do_req(a, model_hit(a), mem_word(a), 1'b1, stall);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
